if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/mips_pkg.sv | 18 +
 rtl/if_fetch_if.sv | 11 +
 rtl/if_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, default vectors and
// the branch-target alignment helper.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC0_0380;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: PC register, one-entry hold buffer for stalls
// and a drain state that swallows the response of an abandoned request.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        ExceptionFlush,
    if_fetch_if.master  imem,
    output logic [31:0] Instruction,
    output logic [31:0] PCAdd4,
    output logic        Valid
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inflight_q, inflight_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc4_q, buf_pc4_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;

    assign redirect = ExceptionFlush | BranchTaken;
    assign target   = ExceptionFlush ? EXC_VECTOR : word_align(BranchTarget);
    assign pc_plus4 = pc_q + 32'd4;

    assign imem.imem_req  = (state_q != HOLD);
    assign imem.imem_addr = (state_q == DRAIN) ? inflight_q : pc_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inflight_d  = inflight_q;
        buf_instr_d = buf_instr_q;
        buf_pc4_d   = buf_pc4_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        case (state_q)
            FETCH: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    // Without an ack the old request is still outstanding.
                    if (!imem.imem_ack) begin
                        inflight_d = pc_q;
                        state_d    = DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    if (Stall) begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc4_d   = pc_plus4;
                        state_d     = HOLD;
                    end else begin
                        instr_d = imem.imem_rdata;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                    end
                end else if (!Stall) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!Stall) begin
                    instr_d = buf_instr_q;
                    pc4_d   = buf_pc4_q;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                // The ack ends the drain; a redirect here only retargets the PC.
                valid_d = 1'b0;
                if (redirect)       pc_d    = target;
                if (imem.imem_ack)  state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_VECTOR;
            inflight_q  <= 32'h0;
            buf_instr_q <= 32'h0;
            buf_pc4_q   <= 32'h0;
            instr_q     <= 32'h0;
            pc4_q       <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            buf_instr_q <= buf_instr_d;
            buf_pc4_q   <= buf_pc4_d;
            instr_q     <= instr_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
        end
    end

    assign Instruction = instr_q;
    assign PCAdd4      = pc4_q;
    assign Valid       = valid_q;

endmodule
